// File: rtl/disp_pkg.sv
// disp_pkg: shared state encoding, channel colour table and sample-to-row mapping for the trace plotter.
package disp_pkg;
   typedef enum logic [2:0] {IDLE, ARM, CAPTURE, DRAW, FIN} state_t;
   localparam logic [15:0] COLOUR [0:3] = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFE0};
   // Full-scale sample lands on row 0; the product is formed at 32 bits before the shift.
   function automatic int row_map(input int s, input int h, input int sw);
      return (h - 1) - ((s * h) >> sw);
   endfunction
endpackage

// File: rtl/trace_buf.sv
// trace_buf: simple dual-port sample buffer, one word per column, registered read with 1-cycle latency.
module trace_buf #(
   parameter int W = 320,
   parameter int DW = 20,
   parameter int AW = $clog2(W)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);
   logic [DW-1:0] mem [W];
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end
endmodule

// File: rtl/disp_trace.sv
// disp_trace: captures one (optionally triggered) multi-channel trace frame and plots it as
// connected vertical segments through a req/ack pixel write port.
module disp_trace
   import disp_pkg::*;
#(
   parameter int AN = 24,
   parameter int DN = 16,
   parameter int BASE = 0,
   parameter int SWAP = 0,
   parameter int W = 320,
   parameter int H = 240,
   parameter int CH = 2,
   parameter int SW = 10
) (
   input  logic             clkSYS,
   input  logic             n_reset,
   input  logic             start,
   output logic             done,
   input  logic             stat,
   input  logic             trig_en,
   input  logic [SW-1:0]    trig_level,
   input  logic             smpl_valid,
   output logic             smpl_ready,
   input  logic [CH*SW-1:0] smpl_data,
   output logic             arb_req,
   input  logic             arb_ack,
   output logic [AN-1:0]    arb_addr,
   output logic [DN-1:0]    arb_data,
   output logic             arb_wr
);
   localparam int XW = $clog2(W);
   localparam int YW = $clog2(H);
   localparam int CW = CH > 1 ? $clog2(CH) : 1;
   state_t state_q, state_d;
   logic [XW-1:0] x_q, x_d;
   logic [CW-1:0] c_q, c_d;
   logic [YW-1:0] y_q, y_d;
   logic [YW-1:0] yprev_q [CH];
   logic [YW-1:0] yprev_d [CH];
   logic [SW-1:0] prev0_q, prev0_d;
   logic prev_ok_q, prev_ok_d, stat_q, stat_d, rd_ok_q, rd_ok_d, row_ok_q, row_ok_d;
   logic done_q, done_d, ready_q, ready_d, req_q, req_d, ack_q, ack_d;
   logic [AN-1:0] addr_q, addr_d;
   logic [DN-1:0] data_q, data_d;
   logic [CH*SW-1:0] rdata;
   logic [SW-1:0] s_cur;
   logic [YW-1:0] ycur, lo, hi;
   logic take, trig, we, acked, last_x, last_c;
   trace_buf #(.W(W), .DW(CH*SW), .AW(XW)) u_buf (
      .clk(clkSYS), .we(we), .waddr(x_q), .wdata(smpl_data), .raddr(x_q), .rdata(rdata)
   );
   always_comb begin
      take = smpl_valid & ready_q;
      trig = prev_ok_q && prev0_q < trig_level && smpl_data[SW-1:0] >= trig_level;
      we = take && (state_q == CAPTURE || (state_q == ARM && trig));
      s_cur = SW'(rdata >> (int'(c_q) * SW));
      ycur = YW'(row_map(int'(s_cur), H, SW));
      lo = (x_q == '0 || ycur < yprev_q[c_q]) ? ycur : yprev_q[c_q];
      hi = (x_q == '0 || ycur > yprev_q[c_q]) ? ycur : yprev_q[c_q];
      // An ack only counts on its rising edge so a held ack cannot retire a second pixel.
      acked = req_q & arb_ack & ~ack_q;
      last_x = x_q == XW'(W - 1);
      last_c = c_q == CW'(CH - 1);
      state_d = state_q;
      x_d = x_q;
      c_d = c_q;
      y_d = y_q;
      yprev_d = yprev_q;
      prev0_d = prev0_q;
      prev_ok_d = prev_ok_q;
      stat_d = stat_q;
      rd_ok_d = rd_ok_q;
      row_ok_d = row_ok_q;
      done_d = 1'b0;
      req_d = req_q;
      ack_d = arb_ack;
      addr_d = addr_q;
      data_d = data_q;
      case (state_q)
         IDLE: if (start) begin
            state_d = trig_en ? ARM : CAPTURE;
            stat_d = stat;
            x_d = '0;
            c_d = '0;
            prev_ok_d = 1'b0;
            rd_ok_d = 1'b0;
            row_ok_d = 1'b0;
         end
         ARM: if (take) begin
            prev0_d = smpl_data[SW-1:0];
            prev_ok_d = 1'b1;
            if (trig) begin
               state_d = CAPTURE;
               x_d = XW'(1);
            end
         end
         CAPTURE: if (take) begin
            x_d = last_x ? '0 : x_q + 1'b1;
            if (last_x) state_d = DRAW;
         end
         DRAW: begin
            rd_ok_d = 1'b1;
            if (rd_ok_q && !row_ok_q) begin
               y_d = lo;
               row_ok_d = 1'b1;
            end
            if (rd_ok_q && row_ok_q && !req_q) begin
               req_d = 1'b1;
               addr_d = (stat_q ? AN'(SWAP) : AN'(BASE)) | AN'(int'(y_q) * W + int'(x_q));
               data_d = DN'(COLOUR[2'(c_q)]);
            end
            if (acked) begin
               req_d = 1'b0;
               if (y_q != hi) y_d = y_q + 1'b1;
               else begin
                  yprev_d[c_q] = ycur;
                  row_ok_d = 1'b0;
                  c_d = last_c ? '0 : c_q + 1'b1;
                  if (last_c) begin
                     x_d = x_q + 1'b1;
                     rd_ok_d = 1'b0;
                  end
                  if (last_c && last_x) begin
                     state_d = FIN;
                     done_d = 1'b1;
                  end
               end
            end
         end
         FIN: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      ready_d = state_d == ARM || state_d == CAPTURE;
   end
   always_ff @(posedge clkSYS or negedge n_reset) begin
      if (!n_reset) begin
         state_q <= IDLE;
         x_q <= '0;
         c_q <= '0;
         y_q <= '0;
         yprev_q <= '{default: '0};
         prev0_q <= '0;
         prev_ok_q <= 1'b0;
         stat_q <= 1'b0;
         rd_ok_q <= 1'b0;
         row_ok_q <= 1'b0;
         done_q <= 1'b0;
         ready_q <= 1'b0;
         req_q <= 1'b0;
         ack_q <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
      end else begin
         state_q <= state_d;
         x_q <= x_d;
         c_q <= c_d;
         y_q <= y_d;
         yprev_q <= yprev_d;
         prev0_q <= prev0_d;
         prev_ok_q <= prev_ok_d;
         stat_q <= stat_d;
         rd_ok_q <= rd_ok_d;
         row_ok_q <= row_ok_d;
         done_q <= done_d;
         ready_q <= ready_d;
         req_q <= req_d;
         ack_q <= ack_d;
         addr_q <= addr_d;
         data_q <= data_d;
      end
   end
   assign done = done_q;
   assign smpl_ready = ready_q;
   assign arb_req = req_q;
   assign arb_addr = addr_q;
   assign arb_data = data_q;
   assign arb_wr = 1'b1;
endmodule

// File: doc/disp_trace.md
DISP_TRACE -- requirements
Module: disp_trace

Interface
REQ-001 Parameter AN, 24, arbiter address width.
REQ-002 Parameter DN, 16, arbiter data (pixel) width.
REQ-003 Parameter BASE, 0, framebuffer base address when stat=0.
REQ-004 Parameter SWAP, 0, framebuffer base address when stat=1.
REQ-005 Parameter W, 320, and H, 240: plot width and height in pixels.
REQ-006 Parameter CH, 2, channel count, range 1..4.
REQ-007 Parameter SW, 10, sample width per channel.
REQ-008 clkSYS  in  1  system clock; the only clock.
REQ-009 n_reset  in  1  reset, asynchronous, active-low.
REQ-010 start  in  1  one-cycle request to capture and draw one frame.
REQ-011 done  out  1  one-cycle pulse when the frame has been drawn.
REQ-012 stat  in  1  buffer select, sampled on the start that leaves Idle.
REQ-013 trig_en  in  1  1 = wait for trigger, 0 = capture immediately.
REQ-014 trig_level  in  SW  trigger level on channel 0.
REQ-015 smpl_valid  in  1  sample word valid.
REQ-016 smpl_ready  out  1  sample word accepted when valid and ready are both high.
REQ-017 smpl_data  in  CH*SW  channel c at bits [c*SW +: SW].
REQ-018 arb  arbiter_if  -  pixel write port: req, ack, addr[AN], data[DN], wr.

Function
REQ-019 The FSM SHALL have states Idle, Arm, Capture, Draw, Fin; start is ignored outside Idle.
REQ-020 Idle on start: go to Arm if trig_en=1, else to Capture.
REQ-021 smpl_ready SHALL be 1 in Arm and Capture only.
REQ-022 Arm SHALL go to Capture on an accepted word whose channel 0 is >= trig_level while the previous accepted channel-0 value was < trig_level; the trigger word SHALL be stored as column 0.
REQ-023 The first word accepted in Arm cannot trigger, since it has no predecessor.
REQ-024 Capture SHALL store accepted words at columns 0..W-1 of an internal W-entry buffer, and SHALL enter Draw after storing column W-1.
REQ-025 Row mapping: y = (H-1) - ((s*H) >> SW), computed at full width before truncation; s = full scale gives y = 0.
REQ-026 Draw order: column x = 0..W-1, and within each column channels 0..CH-1.
REQ-027 Each (x,c) SHALL write every row from min(yprev,ycur) to max(yprev,ycur) inclusive, ascending; yprev is channel c's y at column x-1; at x = 0 only ycur is written.
REQ-028 Pixel address SHALL be (stat_latched ? SWAP : BASE) | (y*W + x).
REQ-029 Pixel data SHALL be the COLOUR[c] entry of the package table; arb.wr SHALL be 1 at all times.
REQ-030 arb.addr and arb.data SHALL be stable while arb.req is 1.
REQ-031 arb.req SHALL drop in the cycle after ack and rise no earlier than two cycles after the previous ack.
REQ-032 Exactly one pixel SHALL be written per ack; a held ack SHALL NOT write twice.
REQ-033 Draw SHALL go to Fin on the ack of the last pixel; Fin SHALL pulse done for one cycle, then return to Idle.
REQ-034 A start coincident with the done pulse SHALL be ignored.

Reset
REQ-035 While n_reset = 0: state = Idle; done, arb.req, smpl_ready = 0; column and channel counters = 0; the trigger history SHALL be marked invalid.
REQ-036 Buffer contents are don't-care after reset; arb.addr and arb.data SHALL reset to 0.
REQ-037 Reset during any state SHALL abort the frame with no further arb.req and no done.

Structure
REQ-038 Package disp_pkg SHALL hold the state enum, the COLOUR[0:3] DN-bit table, and the row-mapping function.
REQ-039 The sample buffer SHALL be a sub-module trace_buf: a simple dual-port RAM, W x CH*SW, with registered read and 1-cycle latency.

Verification
REQ-040 W=4, H=4, CH=1, SW=2, trig_en=0, samples 0,3,3,0, ack every req: writes (x,y) = (0,3), (1,0..3), (2,0), (3,0..3), 10 writes, one done pulse.
REQ-041 Same setup with trig_en=1, level=2, stream 3,1,1,2,3,0,1: capture starts at the 2 (index 3), column 0 y=1.
REQ-042 CH=2, stat=1, SWAP=0x8000: every address has bit 15 set; channel 1 pixels carry COLOUR[1]; per column, channel 0 writes precede channel 1 writes.
REQ-043 ack held high 5 cycles: exactly one write, req low in the next cycle; addr/data unchanged while req is high under random ack delays.
REQ-044 n_reset pulsed mid-Draw: req, done, smpl_ready = 0 immediately; a new start completes a full correct frame.
REQ-045 smpl_valid gaps of random length during Capture: buffer contents and drawn frame are identical to the gap-free run.
